// File: rtl/write_back_stage_if.sv
// rtl/write_back_stage_if.sv - MEM-to-WB stage bundle plus register-file write-back outputs
interface write_back_stage_if #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 32
);
  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic [XLEN-1:0]      read_data;
  logic [XLEN-1:0]      ula_result;
  logic [XLEN-1:0]      pc_plus4;
  logic [XLEN-1:0]      imm;
  logic [1:0]           wb_sel;
  logic [1:0]           mem_size;
  logic                 mem_unsigned;
  logic                 reg_write;
  logic [REGADDR_W-1:0] rd;

  logic [XLEN-1:0]      data_write_mem;
  logic [REGADDR_W-1:0] rd_out;
  logic                 reg_write_out;
  logic                 wb_valid;
  logic [CNT_W-1:0]     retire_count;

  modport master (
    output in_valid, stall, flush, read_data, ula_result, pc_plus4, imm,
           wb_sel, mem_size, mem_unsigned, reg_write, rd,
    input  data_write_mem, rd_out, reg_write_out, wb_valid, retire_count
  );

  modport slave (
    input  in_valid, stall, flush, read_data, ula_result, pc_plus4, imm,
           wb_sel, mem_size, mem_unsigned, reg_write, rd,
    output data_write_mem, rd_out, reg_write_out, wb_valid, retire_count
  );
endinterface

// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - write-back stage register, result select and retire counter
// WB_LOAD_EXT_EN enables sub-word load lane selection with sign/zero extension.
module write_back_stage #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 32
) (
  input logic               clk,
  input logic               rst,
  write_back_stage_if.slave wb
);
  logic                 valid_q;
  logic                 reg_write_q;
  logic [REGADDR_W-1:0] rd_q;
  logic [1:0]           wb_sel_q;
  logic [XLEN-1:0]      read_data_q;
  logic [XLEN-1:0]      ula_result_q;
  logic [XLEN-1:0]      pc_plus4_q;
  logic [XLEN-1:0]      imm_q;
  logic [CNT_W-1:0]     retire_q;
  logic [XLEN-1:0]      load_data;
  logic [XLEN-1:0]      result;
`ifdef WB_LOAD_EXT_EN
  localparam int OFF_W = $clog2(XLEN / 8);
  logic [1:0]           mem_size_q;
  logic                 mem_unsigned_q;
  logic [OFF_W-1:0]     off;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      rd_q           <= '0;
      wb_sel_q       <= 2'b00;
      read_data_q    <= '0;
      ula_result_q   <= '0;
      pc_plus4_q     <= '0;
      imm_q          <= '0;
      retire_q       <= '0;
`ifdef WB_LOAD_EXT_EN
      mem_size_q     <= 2'b00;
      mem_unsigned_q <= 1'b0;
`endif
    end else begin
      // The occupant retires on any unstalled edge, even one that also flushes.
      if (valid_q && !wb.stall) retire_q <= retire_q + CNT_W'(1);
      if (wb.flush) begin
        valid_q <= 1'b0;
      end else if (!wb.stall) begin
        valid_q        <= wb.in_valid;
        reg_write_q    <= wb.reg_write;
        rd_q           <= wb.rd;
        wb_sel_q       <= wb.wb_sel;
        read_data_q    <= wb.read_data;
        ula_result_q   <= wb.ula_result;
        pc_plus4_q     <= wb.pc_plus4;
        imm_q          <= wb.imm;
`ifdef WB_LOAD_EXT_EN
        mem_size_q     <= wb.mem_size;
        mem_unsigned_q <= wb.mem_unsigned;
`endif
      end
    end
  end

`ifdef WB_LOAD_EXT_EN
  // Keeps the low 'bits' of v, then sign- or zero-fills the upper part.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input int bits,
                                             input logic zero_fill);
    logic [XLEN-1:0] t;
    logic [XLEN-1:0] s;
    t = v << (XLEN - bits);
    s = $signed(t) >>> (XLEN - bits);
    if (zero_fill) return t >> (XLEN - bits);
    return s;
  endfunction

  assign off = ula_result_q[OFF_W-1:0];

  always_comb begin
    load_data = read_data_q;
    case (mem_size_q)
      2'b00: load_data = extend(read_data_q >> {off, 3'b000}, 8, mem_unsigned_q);
      2'b01: load_data = extend(read_data_q >> {off & ~OFF_W'(1), 3'b000}, 16, mem_unsigned_q);
      default: begin
        // A doubleword request on a 32-bit datapath degrades to a word load.
        if (XLEN == 64 && mem_size_q == 2'b11) load_data = read_data_q;
        else load_data = extend(read_data_q >> {off & ~OFF_W'(3), 3'b000}, 32, mem_unsigned_q);
      end
    endcase
  end
`else
  assign load_data = read_data_q;
`endif

  always_comb begin
    result = ula_result_q;
    case (wb_sel_q)
      2'b00:   result = ula_result_q;
      2'b01:   result = load_data;
      2'b10:   result = pc_plus4_q;
      default: result = imm_q;
    endcase
  end

  assign wb.data_write_mem = result;
  assign wb.rd_out         = rd_q;
  assign wb.reg_write_out  = valid_q & reg_write_q & (rd_q != '0);
  assign wb.wb_valid       = valid_q;
  assign wb.retire_count   = retire_q;
endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - scoreboard bench for write_back_stage (32-bit/CNT_W=4 and 64-bit instances)
module tb_write_back_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, stall, flush, mem_unsigned, reg_write;
  logic [1:0]  wb_sel, mem_size;
  logic [4:0]  rd;
  logic [63:0] read_data, ula_result, pc_plus4, imm;

  write_back_stage_if #(.XLEN(32), .REGADDR_W(5), .CNT_W(4))  if32 ();
  write_back_stage_if #(.XLEN(64), .REGADDR_W(5), .CNT_W(32)) if64 ();

  assign if32.in_valid = in_valid;      assign if64.in_valid = in_valid;
  assign if32.stall = stall;            assign if64.stall = stall;
  assign if32.flush = flush;            assign if64.flush = flush;
  assign if32.read_data = read_data[31:0];   assign if64.read_data = read_data;
  assign if32.ula_result = ula_result[31:0]; assign if64.ula_result = ula_result;
  assign if32.pc_plus4 = pc_plus4[31:0];     assign if64.pc_plus4 = pc_plus4;
  assign if32.imm = imm[31:0];          assign if64.imm = imm;
  assign if32.wb_sel = wb_sel;          assign if64.wb_sel = wb_sel;
  assign if32.mem_size = mem_size;      assign if64.mem_size = mem_size;
  assign if32.mem_unsigned = mem_unsigned; assign if64.mem_unsigned = mem_unsigned;
  assign if32.reg_write = reg_write;    assign if64.reg_write = reg_write;
  assign if32.rd = rd;                  assign if64.rd = rd;

  write_back_stage #(.XLEN(32), .REGADDR_W(5), .CNT_W(4)) u32 (.clk(clk), .rst(rst), .wb(if32));
  write_back_stage #(.XLEN(64), .REGADDR_W(5), .CNT_W(32)) u64 (.clk(clk), .rst(rst), .wb(if64));

  typedef struct {
    logic        valid;
    logic        rwo;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  logic        mv[2];
  logic        mrw[2];
  logic [4:0]  mrd[2];
  logic [63:0] md[2];
  logic [31:0] mc[2];
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_data(input int xl, input logic [1:0] sel, input logic [1:0] size,
                                           input logic uns, input logic [63:0] rdata, input logic [63:0] ula,
                                           input logic [63:0] pc4, input logic [63:0] im);
    logic [63:0] m, v;
    m = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    v = rdata & m;
`ifdef WB_LOAD_EXT_EN
    begin
      int nb, off, bytes;
      nb = xl / 8;
      off = int'(ula[2:0]) % nb;
      bytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b11 && xl == 64) ? 8 : 4;
      off = off - (off % bytes);
      v = '0;
      for (int i = 0; i < bytes * 8; i++) v[i] = rdata[off * 8 + i];
      if (!uns && v[bytes * 8 - 1]) for (int i = bytes * 8; i < 64; i++) v[i] = 1'b1;
    end
`endif
    case (sel)
      2'b00:   return ula & m;
      2'b01:   return v & m;
      2'b10:   return pc4 & m;
      default: return im & m;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; mrw[k] = 1'b0; mrd[k] = '0; md[k] = '0; mc[k] = '0;
    end
  endtask

  task automatic step();
    exp_t e;
    exp_t o;
    for (int k = 0; k < 2; k++) begin
      int xl;
      xl = (k == 1) ? 64 : 32;
      if (mv[k] && !stall) mc[k] = (k == 1) ? mc[k] + 1 : (mc[k] + 1) & 32'hF;
      if (flush) mv[k] = 1'b0;
      else if (!stall) begin
        mv[k]  = in_valid;
        mrw[k] = reg_write;
        mrd[k] = rd;
        md[k]  = exp_data(xl, wb_sel, mem_size, mem_unsigned, read_data, ula_result, pc_plus4, imm);
      end
      e.valid = mv[k];
      e.rwo   = mv[k] && mrw[k] && (mrd[k] != 0);
      e.rd    = mrd[k];
      e.data  = md[k];
      e.cnt   = mc[k];
      if (k == 0) q32.push_back(e); else q64.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      string p;
      if (k == 0) begin
        e = q32.pop_front();
        o.valid = if32.wb_valid; o.rwo = if32.reg_write_out; o.rd = if32.rd_out;
        o.data = 64'(if32.data_write_mem); o.cnt = 32'(if32.retire_count);
        p = "u32";
      end else begin
        e = q64.pop_front();
        o.valid = if64.wb_valid; o.rwo = if64.reg_write_out; o.rd = if64.rd_out;
        o.data = if64.data_write_mem; o.cnt = if64.retire_count;
        p = "u64";
      end
      check({p, ".wb_valid"}, 64'(o.valid), 64'(e.valid));
      check({p, ".reg_write_out"}, 64'(o.rwo), 64'(e.rwo));
      check({p, ".retire_count"}, 64'(o.cnt), 64'(e.cnt));
      if (e.valid) begin
        check({p, ".rd_out"}, 64'(o.rd), 64'(e.rd));
        check({p, ".data_write_mem"}, o.data, e.data);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [63:0] rdata, input logic [63:0] ula,
                       input logic [1:0] size, input logic uns, input logic rw, input logic [4:0] rdi);
    in_valid = v; wb_sel = sel; read_data = rdata; ula_result = ula;
    mem_size = size; mem_unsigned = uns; reg_write = rw; rd = rdi;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".u32.wb_valid"}, 64'(if32.wb_valid), 64'd0);
    check({tag, ".u32.reg_write_out"}, 64'(if32.reg_write_out), 64'd0);
    check({tag, ".u32.rd_out"}, 64'(if32.rd_out), 64'd0);
    check({tag, ".u32.retire_count"}, 64'(if32.retire_count), 64'd0);
    check({tag, ".u32.data_write_mem"}, 64'(if32.data_write_mem), 64'd0);
    check({tag, ".u64.wb_valid"}, 64'(if64.wb_valid), 64'd0);
    check({tag, ".u64.reg_write_out"}, 64'(if64.reg_write_out), 64'd0);
    check({tag, ".u64.retire_count"}, 64'(if64.retire_count), 64'd0);
    check({tag, ".u64.data_write_mem"}, if64.data_write_mem, 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    pc_plus4 = 64'h0000_0000_0000_1004;
    imm = 64'hFFFF_FFFF_ABCD_E000;
    drive(1'b0, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    drive(1'b1, 2'b01, 64'h0000_0000_1234_80FF, 64'd1, 2'b00, 1'b0, 1'b1, 5'd3);
    step();
`ifdef WB_LOAD_EXT_EN
    check("byte_signed_off1", 64'(if32.data_write_mem), 64'h0000_0000_FFFF_FF80);
`else
    check("byte_passthrough", 64'(if32.data_write_mem), 64'h0000_0000_1234_80FF);
`endif
    drive(1'b1, 2'b01, 64'h0000_0000_1234_80FF, 64'd2, 2'b01, 1'b1, 1'b1, 5'd4);
    step();
`ifdef WB_LOAD_EXT_EN
    check("half_unsigned_off2", 64'(if32.data_write_mem), 64'h0000_0000_0000_1234);
`else
    check("half_passthrough", 64'(if32.data_write_mem), 64'h0000_0000_1234_80FF);
`endif
    drive(1'b1, 2'b00, '0, 64'd5, 2'b10, 1'b0, 1'b1, 5'd0);
    step();
    check("x0_write_suppressed", 64'(if32.reg_write_out), 64'd0);
    drive(1'b1, 2'b10, '0, 64'd9, 2'b10, 1'b0, 1'b1, 5'd1);
    step();
    drive(1'b1, 2'b11, '0, 64'd9, 2'b10, 1'b0, 1'b1, 5'd2);
    step();

    drive(1'b1, 2'b00, '0, 64'h77, 2'b10, 1'b0, 1'b1, 5'd7);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, '0, 64'(i + 100), 2'b10, 1'b0, 1'b1, 5'd9);
      stall = 1'b1;
      step();
      check("rd_held_in_stall", 64'(if32.rd_out), 64'd7);
    end
    stall = 1'b1; flush = 1'b1;
    step();
    check("flush_over_stall", 64'(if32.wb_valid), 64'd0);
    drive(1'b0, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0, 5'd0);
    step();

    drive(1'b1, 2'b01, 64'h8000_0000_0000_0001, 64'd0, 2'b11, 1'b0, 1'b1, 5'd10);
    step();
    check("dword_unchanged", if64.data_write_mem, 64'h8000_0000_0000_0001);
    drive(1'b1, 2'b01, 64'hFFFF_FFFE_0000_0000, 64'd4, 2'b10, 1'b0, 1'b1, 5'd11);
    step();
`ifdef WB_LOAD_EXT_EN
    check("word_off4_signed", if64.data_write_mem, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    check("word_passthrough", if64.data_write_mem, 64'hFFFF_FFFE_0000_0000);
`endif

    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            2'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      pc_plus4 = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
    end

    drive(1'b1, 2'b00, '0, 64'h55, 2'b10, 1'b0, 1'b1, 5'd5);
    step();
    #1;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 2'b00, '0, 64'(i), 2'b10, 1'b0, 1'b1, 5'(i + 1));
      step();
    end
    drive(1'b0, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0, 5'd0);
    step();
    check("retire_wrap_cnt4", 64'(if32.retire_count), 64'd1);
    check("retire_17_cnt32", 64'(if64.retire_count), 64'd17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter REGADDR_W, default 5, destination register index width.
REQ-003 Parameter CNT_W, default 32, width of the retire counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  MEM stage presents a valid instruction.
REQ-007 stall  in  1  hold the stage register.
REQ-008 flush  in  1  invalidate the stage register.
REQ-009 read_data  in  XLEN  raw data-memory read word.
REQ-010 ula_result  in  XLEN  ALU result; low bits are the load byte offset.
REQ-011 pc_plus4  in  XLEN  link value for JAL/JALR.
REQ-012 imm  in  XLEN  immediate for LUI.
REQ-013 wb_sel  in  2  source: 00 ALU, 01 memory, 10 pc_plus4, 11 imm.
REQ-014 mem_size  in  2  load size: 00 byte, 01 half, 10 word, 11 doubleword.
REQ-015 mem_unsigned  in  1  zero-extend the load when 1.
REQ-016 reg_write  in  1  instruction writes the register file.
REQ-017 rd  in  REGADDR_W  destination register index.
REQ-018 data_write_mem  out  XLEN  write-back data to the register file.
REQ-019 rd_out  out  REGADDR_W  registered destination index.
REQ-020 reg_write_out  out  1  register-file write enable.
REQ-021 wb_valid  out  1  stage holds a valid instruction.
REQ-022 retire_count  out  CNT_W  count of retired valid instructions.

Function
REQ-023 Rising edge, flush=1: valid register <= 0; other fields don't-care; flush has priority over stall.
REQ-024 Rising edge, flush=0, stall=1: all stage registers hold.
REQ-025 Rising edge, flush=0, stall=0: capture all inputs; valid register <= in_valid.
REQ-026 Latency: outputs reflect captured inputs one cycle after capture; data path from stage registers to data_write_mem is combinational.
REQ-027 wb_valid equals the valid register.
REQ-028 reg_write_out = valid AND captured reg_write AND (captured rd != 0); writes to x0 are suppressed.
REQ-029 data_write_mem selected by captured wb_sel: ALU result, extended load, pc_plus4, or imm.
REQ-030 Load byte offset = captured ula_result[log2(XLEN/8)-1:0]; byte selects lane at offset; half uses offset with bit 0 ignored; word uses offset with bits 1:0 ignored.
REQ-031 mem_size 11 is doubleword when XLEN=64 and is treated as word when XLEN=32.
REQ-032 Extension: selected field sign-extended to XLEN when mem_unsigned=0, zero-extended when 1; a full-width load is passed unchanged.
REQ-033 retire_count increments by 1 on each rising edge where wb_valid=1 and stall=0; wraps modulo 2^CNT_W.
REQ-034 Simultaneous flush and valid occupancy: the occupying instruction still counts if stall=0 on that edge.
REQ-035 When wb_valid=0, data_write_mem is don't-care and reg_write_out is 0.

Reset
REQ-036 rst low asynchronously clears the valid register, captured reg_write, rd_out and retire_count to 0; data_write_mem reads 0.
REQ-037 Reset asserted mid-operation discards the held instruction; no write enable is produced until a new capture.
REQ-038 Deassertion takes effect at the next rising edge; first capture possible on that edge.

Configuration
REQ-039 Macro WB_LOAD_EXT_EN defined: sub-word load selection and extension per REQ-030..REQ-032.
REQ-040 WB_LOAD_EXT_EN undefined: memory source passes read_data unchanged; mem_size and mem_unsigned are ignored; retire and select logic unchanged.

Verification
REQ-041 XLEN=32, wb_sel=01, read_data=0x1234_80FF, ula_result[1:0]=1, byte, signed -> data_write_mem=0xFFFF_FF80 one cycle later.
REQ-042 Same data, half, unsigned, offset 2 -> 0x0000_1234; with WB_LOAD_EXT_EN undefined -> 0x1234_80FF.
REQ-043 reg_write=1, rd=0, wb_sel=00, ula_result=0x5 -> reg_write_out=0, wb_valid=1, retire_count +1.
REQ-044 Capture rd=7, then stall=1 for 3 cycles with new inputs -> rd_out stays 7, retire_count unchanged during stall; flush with stall=1 -> wb_valid=0 next cycle.
REQ-045 CNT_W=4, 17 valid unstalled instructions -> retire_count=1; rst low mid-stream -> all outputs 0 immediately, no clock needed.
REQ-046 XLEN=64, doubleword, signed, read_data=0x8000_0000_0000_0001 -> passed unchanged; word at offset 4 of 0xFFFF_FFFE_0000_0000 -> 0xFFFF_FFFF_FFFF_FFFE.
